// File: rtl/btn_event_ctrl.sv
// Button-event controller: one shared, time-multiplexed debouncer feeding a small event FIFO.
// Define BTN_RELEASE_EVT_EN to queue release events as well as presses.
module btn_event_ctrl #(
  parameter int N_BTN      = 5,
  parameter int TICK_DIV   = 100000,
  parameter int DB_COUNT   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_code,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  // state  | meaning
  // S_IDLE | waiting for the next sample tick
  // S_SCAN | servicing button idx_q, one button per cycle

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       cnt_q [N_BTN];
  logic [7:0]       cnt_d [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             evt, evt_rel, push, pop, full, wr_en, drop;
  logic [3:0]       push_code;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    evt     = 1'b0;
    evt_rel = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (sync2_q[idx_q] == level_q[idx_q]) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_q[idx_q] == 8'(DB_COUNT - 1)) begin
          level_d[idx_q] = ~level_q[idx_q];
          cnt_d[idx_q]   = '0;
          evt            = 1'b1;
          evt_rel        = level_q[idx_q];
        end else begin
          cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
        end
        if (idx_q == 3'(N_BTN - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BTN_RELEASE_EVT_EN
  assign push = evt;
`else
  assign push = evt && !evt_rel;
`endif
  assign push_code = {evt_rel, idx_q};

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = valid_q && evt_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = push_code;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    // Old write pointer delays valid by one edge after a push, while pops take effect at once.
    valid_d  = (wr_ptr_q != rd_ptr_d);
    ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      state_q    <= S_IDLE;
      idx_q      <= '0;
      level_q    <= '0;
      for (int k = 0; k < N_BTN; k++) cnt_q[k] <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign btn_level = level_q;
  assign evt_valid = valid_q;
  assign evt_code  = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_ovf   = ovf_q;

endmodule
